// File: rtl/fb_scan_reader.sv
// Raster-order read side of the VGA pixel buffer: fetches pixels over the shared
// buffer port into a credit-limited prefetch FIFO and hands out 3-3-2 expanded RGB.
module fb_scan_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 16,
  parameter int RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iFrameStart,
  output logic              oRdReq,
  output logic [ADDR_W-1:0] oRdAddr,
  input  logic              iRdGnt,
  input  logic [7:0]        iRdData,
  input  logic              iPixReq,
  output logic              oPixValid,
  output logic [9:0]        oR,
  output logic [9:0]        oG,
  output logic [9:0]        oB,
  output logic              oUnderflow
);

  // state | meaning
  // FETCH | walking the frame, issuing reads while credit is available
  // DONE  | whole frame requested; idle until the next frame start
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  logic [0:0]        state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;
  logic [RD_LAT-1:0] vld_sr;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [OCC_W-1:0]  occ;
  logic [7:0]        head;
  logic              rd_req;
  logic              accept;
  logic              push;
  logic              pop;
  logic              last_addr;

  // Reads in flight count against FIFO space, so a returning read always has a slot.
  always_comb begin
    occ = OCC_W'(count);
    for (int i = 0; i < RD_LAT; i++) begin
      occ = occ + OCC_W'(vld_sr[i]);
    end
  end

  assign rd_req    = (state == ST_FETCH) && (occ < OCC_W'(FIFO_DEPTH));
  assign accept    = rd_req & iRdGnt & ~iFrameStart;
  assign push      = vld_sr[RD_LAT-1] & ~iFrameStart;
  assign pop       = iPixReq & (count != '0) & ~iFrameStart;
  assign last_addr = (col == COL_W'(H_ACTIVE - 1)) && (row == ROW_W'(V_ACTIVE - 1));
  assign head      = mem[rd_ptr];
  assign oRdReq    = rd_req;
  assign oRdAddr   = addr;

  // Separate column/row counters detect end of frame without a multiplier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_DONE;
      col   <= '0;
      row   <= '0;
      addr  <= '0;
    end else if (iFrameStart) begin
      state <= ST_FETCH;
      col   <= '0;
      row   <= '0;
      addr  <= '0;
    end else if (accept) begin
      addr <= addr + ADDR_W'(1);
      if (last_addr) begin
        state <= ST_DONE;
        col   <= '0;
        row   <= '0;
      end else if (col == COL_W'(H_ACTIVE - 1)) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_sr <= '0;
    end else if (iFrameStart) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= accept;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (iFrameStart) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= iRdData;
  end

  // A request on an empty FIFO still produces a (black) pixel so the raster keeps timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oPixValid  <= 1'b0;
      oR         <= '0;
      oG         <= '0;
      oB         <= '0;
      oUnderflow <= 1'b0;
    end else if (iFrameStart) begin
      oPixValid  <= 1'b0;
      oR         <= '0;
      oG         <= '0;
      oB         <= '0;
      oUnderflow <= 1'b0;
    end else if (iPixReq) begin
      oPixValid <= 1'b1;
      if (pop) begin
        oR <= {head[7:5], head[7:5], head[7:5], head[7]};
        oG <= {head[4:2], head[4:2], head[4:2], head[4]};
        oB <= {head[1:0], head[1:0], head[1:0], head[1:0], head[1:0]};
      end else begin
        oR         <= '0;
        oG         <= '0;
        oB         <= '0;
        oUnderflow <= 1'b1;
      end
    end else begin
      oPixValid <= 1'b0;
      oR        <= '0;
      oG        <= '0;
      oB        <= '0;
    end
  end

endmodule

// File: tb/tb_fb_scan_reader.sv
// Randomized bench for fb_scan_reader on a small 20x15 frame, checked every cycle
// against a queue-based model of the buffer port, prefetch FIFO and pixel output.
module tb_fb_scan_reader;
  localparam int H = 20, V = 15, NPIX = H * V, AW = 19, DEPTH = 16, LAT = 2;

  logic clk = 1'b0;
  logic reset, iFrameStart, oRdReq, iRdGnt, iPixReq, oPixValid, oUnderflow;
  logic [AW-1:0] oRdAddr;
  logic [7:0] iRdData;
  logic [9:0] oR, oG, oB;

  always #5 clk = ~clk;

  fb_scan_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .iFrameStart(iFrameStart), .oRdReq(oRdReq), .oRdAddr(oRdAddr),
    .iRdGnt(iRdGnt), .iRdData(iRdData), .iPixReq(iPixReq), .oPixValid(oPixValid),
    .oR(oR), .oG(oG), .oB(oB), .oUnderflow(oUnderflow));

  typedef struct {int addr; logic [7:0] data; int due; bit live;} rd_t;
  typedef struct {int addr; logic [7:0] data;} px_t;

  rd_t rq[$];
  px_t fifo[$];
  int checks = 0, errors = 0;
  bit fetching, exp_valid, exp_black, exp_uf, in_reset;
  px_t exp_px;
  int next_addr, edge_n, model_pops, dut_acc, dut_valid_cnt, phase;
  logic [7:0] salt;

  function automatic logic [7:0] mem_f(int a);
    logic [31:0] t;
    t = a;
    return t[7:0] ^ t[15:8] ^ salt;
  endfunction

  // 3-bit field replicated to 10 bits is r*146 + r/4; 2-bit field is b*341.
  function automatic logic [29:0] expand(logic [7:0] c);
    int r, g, b;
    r = c[7:5]; g = c[4:2]; b = c[1:0];
    return {10'(r * 146 + r / 4), 10'(g * 146 + g / 4), 10'(b * 341)};
  endfunction

  function automatic int occ();
    int n;
    n = fifo.size();
    foreach (rq[i]) if (rq[i].live) n++;
    return n;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo.delete();
    foreach (rq[i]) rq[i].live = 1'b0;
    fetching = 1'b0; next_addr = 0; exp_valid = 1'b0; exp_black = 1'b0; exp_uf = 1'b0;
  endtask

  task automatic model_update(bit fs, bit gnt, bit pix, int e);
    bit req, had;
    if (!in_reset) begin
      req = fetching && (occ() < DEPTH);
      if (fs) begin
        fifo.delete();
        foreach (rq[i]) rq[i].live = 1'b0;
        fetching = 1'b1; next_addr = 0; exp_valid = 1'b0; exp_uf = 1'b0;
      end else begin
        had = fifo.size() > 0;
        exp_valid = pix;
        exp_black = 1'b0;
        if (pix) begin
          if (had) begin
            exp_px = fifo.pop_front();
            model_pops++;
          end else begin
            exp_black = 1'b1;
            exp_uf = 1'b1;
          end
        end
        foreach (rq[i]) if (rq[i].due == e && rq[i].live) fifo.push_back('{rq[i].addr, rq[i].data});
        if (req && gnt) begin
          rq.push_back('{next_addr, mem_f(next_addr), e + LAT, 1'b1});
          next_addr++;
          if (next_addr == NPIX) fetching = 1'b0;
        end
      end
    end
    while (rq.size() > 0 && rq[0].due <= e) void'(rq.pop_front());
  endtask

  task automatic check_outputs();
    bit er;
    logic [29:0] c;
    er = fetching && (occ() < DEPTH);
    chk("rd_req", oRdReq, er);
    if (er) chk("rd_addr", oRdAddr, next_addr);
    chk("pix_valid", oPixValid, exp_valid);
    if (exp_valid) begin
      c = exp_black ? 30'd0 : expand(exp_px.data);
      chk("red", oR, c[29:20]);
      chk("green", oG, c[19:10]);
      chk("blue", oB, c[9:0]);
      if (phase == 2 && !exp_black && exp_px.addr == 5) begin
        chk("addr5_red", oR, 0);
        chk("addr5_green", oG, 'h092);
        chk("addr5_blue", oB, 'h155);
      end
    end
    chk("underflow", oUnderflow, exp_uf);
    if (phase == 2 && oPixValid) dut_valid_cnt++;
  endtask

  task automatic cycle(bit fs, bit gnt, bit pix);
    int e;
    e = edge_n + 1;
    iFrameStart = fs; iRdGnt = gnt; iPixReq = pix;
    iRdData = 8'($urandom);
    foreach (rq[i]) if (rq[i].due == e) iRdData = rq[i].data;
    if (!in_reset && oRdReq && gnt && !fs) dut_acc++;
    model_update(fs, gnt, pix, e);
    edge_n = e;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    reset = 1'b1; iFrameStart = 1'b0; iRdGnt = 1'b0; iPixReq = 1'b0; iRdData = 8'h00;
    salt = 8'h00; phase = 0; edge_n = 0; model_pops = 0; dut_acc = 0; dut_valid_cnt = 0;
    in_reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk("reset_req", oRdReq, 0);
    chk("reset_addr", oRdAddr, 0);
    chk("reset_valid", oPixValid, 0);
    chk("reset_rgb", {oR, oG, oB}, 0);
    chk("reset_underflow", oUnderflow, 0);
    cycle(0, 0, 0); cycle(0, 0, 0);
    reset = 1'b0; in_reset = 1'b0;
    repeat (3) cycle(0, 1, 0);

    // prefill: continuous grant, no consumption
    phase = 1; dut_acc = 0;
    cycle(1, 1, 0);
    repeat (30) cycle(0, 1, 0);
    chk("prefill_accepts", dut_acc, 16);
    chk("prefill_req_low", oRdReq, 0);

    // whole frame streamed in order
    phase = 2; model_pops = 0; dut_valid_cnt = 0;
    for (int n = 0; n < 3000 && model_pops < NPIX; n++) cycle(0, 1, 1);
    repeat (3) cycle(0, 1, 0);
    chk("frame_pixels", dut_valid_cnt, NPIX);
    chk("frame_no_underflow", oUnderflow, 0);
    chk("done_req_low", oRdReq, 0);

    // sparse grant: starves the FIFO
    phase = 3; salt = 8'h11;
    cycle(1, 1, 0);
    chk("restart_req", oRdReq, 1);
    chk("restart_addr", oRdAddr, 0);
    repeat (400) cycle(0, ($urandom % 4) == 0, 1);
    chk("starved_underflow", oUnderflow, 1);

    // random grant and consumption over a full frame
    phase = 4; salt = 8'($urandom);
    cycle(1, 1, 0);
    for (int n = 0; n < 6000 && (fetching || occ() > 0); n++)
      cycle(0, ($urandom % 2) == 1, ($urandom % 3) == 0);
    chk("random_frame_req_low", oRdReq, 0);

    // frame restart with two reads in flight
    phase = 5; salt = 8'h3C;
    cycle(1, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0);
    salt = 8'hA7;
    cycle(1, 1, 0);
    repeat (10) cycle(0, 1, 0);
    cycle(0, 1, 1);
    chk("kill_first_valid", oPixValid, 1);
    chk("kill_first_red", oR, 'h2DB);
    chk("kill_first_green", oG, 'h092);
    chk("kill_first_blue", oB, 'h3FF);
    chk("kill_no_underflow", oUnderflow, 0);

    // asynchronous reset mid-frame
    phase = 6; salt = 8'h5A;
    cycle(1, 1, 0);
    repeat (25) cycle(0, 1, $urandom % 2);
    #2 reset = 1'b1;
    #1;
    chk("async_req", oRdReq, 0);
    chk("async_addr", oRdAddr, 0);
    chk("async_valid", oPixValid, 0);
    chk("async_rgb", {oR, oG, oB}, 0);
    chk("async_underflow", oUnderflow, 0);
    in_reset = 1'b1;
    model_reset();
    @(negedge clk);
    edge_n++;
    check_outputs();
    cycle(0, 0, 0); cycle(0, 0, 0);
    reset = 1'b0; in_reset = 1'b0;
    salt = 8'hC3;
    cycle(1, 1, 0);
    chk("resume_req", oRdReq, 1);
    chk("resume_addr", oRdAddr, 0);
    repeat (40) cycle(0, 1, $urandom % 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
